// File: rtl/game_pkg.sv
// Shared game-flow types: state encoding and its width.
package game_pkg;

    localparam int GAME_STATE_W = 4;

    typedef enum logic [GAME_STATE_W-1:0] {
        ST_PLAY    = 4'd0,
        ST_OVER    = 4'd1,
        ST_IDLE    = 4'd2,
        ST_RESPAWN = 4'd3,
        ST_PAUSE   = 4'd4
    } game_state_e;

endpackage

// File: rtl/game_flow_ctrl_key_sync.sv
// key_edge_sync: two-flop synchroniser for an active-low key plus a
// one-cycle press pulse on the synchronised falling edge.
module key_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_press = r_prev & ~r_sync2;

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: idle/play/respawn/over sequencing with per-ball enables,
// lives, level, score and high score. Define GAME_PAUSE_EN to add PAUSE.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_BALLS      = 4,
    parameter int LIVES          = 3,
    parameter int RESPAWN_CYCLES = 25000000,
    parameter int LEVEL_HITS     = 10,
    parameter int SCORE_W        = 18
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    keyStart,
    input  logic                    keyPause,
    input  logic [NUM_BALLS-1:0]    ball_lost,
    input  logic                    hit_pulse,
    output logic [GAME_STATE_W-1:0] game_state,
    output logic [NUM_BALLS-1:0]    ball_active,
    output logic [3:0]              lives,
    output logic [2:0]              level,
    output logic [SCORE_W-1:0]      score,
    output logic [SCORE_W-1:0]      high_score
);

    localparam int RCW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam int HCW = (LEVEL_HITS > 1) ? $clog2(LEVEL_HITS) : 1;
    localparam logic [RCW-1:0]       RESPAWN_LOAD = RCW'(RESPAWN_CYCLES - 1);
    localparam logic [HCW-1:0]       HIT_LAST     = HCW'(LEVEL_HITS - 1);
    localparam logic [2:0]           MAX_LEVEL    = 3'(NUM_BALLS - 1);
    localparam logic [3:0]           LIVES_INIT   = 4'(LIVES);
    localparam logic [NUM_BALLS-1:0] FIRST_BALL   = NUM_BALLS'(1);

    game_state_e          r_state,   r_state_nxt;
    logic [NUM_BALLS-1:0] r_active,  r_active_nxt;
    logic [3:0]           r_lives,   r_lives_nxt;
    logic [2:0]           r_level,   r_level_nxt;
    logic [SCORE_W-1:0]   r_score,   r_score_nxt;
    logic [SCORE_W-1:0]   r_high,    r_high_nxt;
    logic [RCW-1:0]       r_resp,    r_resp_nxt;
    logic [HCW-1:0]       r_hits,    r_hits_nxt;

    logic                 w_start_press;
    logic                 w_pause_press;
    logic [NUM_BALLS-1:0] w_served;
    logic [NUM_BALLS-1:0] w_new_ball;
    logic [NUM_BALLS-1:0] w_survivors;
    logic                 w_hit_wrap;
    logic                 w_level_up;

    key_edge_sync u_start_sync (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset),
        .i_key_n (keyStart),
        .o_press (w_start_press)
    );

`ifdef GAME_PAUSE_EN
    key_edge_sync u_pause_sync (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset),
        .i_key_n (keyPause),
        .o_press (w_pause_press)
    );
`else
    logic w_unused_pause;
    assign w_unused_pause = keyPause;
    assign w_pause_press  = 1'b0;
`endif

    // w_served: balls 0..level; w_new_ball: the one a level-up brings in
    always_comb begin
        w_served   = '0;
        w_new_ball = '0;
        for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            w_served[i]   = (i <= 32'(r_level));
            w_new_ball[i] = (i == 32'(r_level) + 32'd1);
        end
    end

    assign w_survivors = r_active & ~ball_lost;
    assign w_hit_wrap  = hit_pulse && (r_hits == HIT_LAST);
    assign w_level_up  = w_hit_wrap && (r_level < MAX_LEVEL);

    always_comb begin
        r_state_nxt  = r_state;
        r_active_nxt = r_active;
        r_lives_nxt  = r_lives;
        r_level_nxt  = r_level;
        r_score_nxt  = r_score;
        r_high_nxt   = r_high;
        r_resp_nxt   = r_resp;
        r_hits_nxt   = r_hits;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_start_press) begin
                    r_state_nxt  = ST_PLAY;
                    r_active_nxt = FIRST_BALL;
                    r_lives_nxt  = LIVES_INIT;
                    r_level_nxt  = '0;
                    r_score_nxt  = '0;
                    r_hits_nxt   = '0;
                end
            end
            ST_PLAY: begin
                if (w_pause_press) begin
                    r_state_nxt = ST_PAUSE;
                end else begin
                    if (hit_pulse) begin
                        r_score_nxt = (r_score == '1) ? r_score : r_score + 1'b1;
                        r_hits_nxt  = w_hit_wrap ? '0 : r_hits + 1'b1;
                        if (w_level_up)
                            r_level_nxt = r_level + 3'd1;
                    end
                    // Final loss suppresses the level-up ball; high score sees this edge's hit
                    if (w_survivors == '0) begin
                        r_active_nxt = '0;
                        r_lives_nxt  = r_lives - 4'd1;
                        if (r_lives == 4'd1) begin
                            r_state_nxt = ST_OVER;
                            r_high_nxt  = (r_score_nxt > r_high) ? r_score_nxt : r_high;
                        end else begin
                            r_state_nxt = ST_RESPAWN;
                            r_resp_nxt  = RESPAWN_LOAD;
                        end
                    end else begin
                        r_active_nxt = w_survivors | (w_level_up ? w_new_ball : '0);
                    end
                end
            end
            ST_RESPAWN: begin
                r_active_nxt = '0;
                if (r_resp == '0) begin
                    r_state_nxt  = ST_PLAY;
                    r_active_nxt = w_served;
                end else begin
                    r_resp_nxt = r_resp - 1'b1;
                end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                if (w_pause_press)
                    r_state_nxt = ST_PLAY;
            end
`endif
            default: r_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_active <= '0;
            r_lives  <= LIVES_INIT;
            r_level  <= '0;
            r_score  <= '0;
            r_high   <= '0;
            r_resp   <= '0;
            r_hits   <= '0;
        end else begin
            r_state  <= r_state_nxt;
            r_active <= r_active_nxt;
            r_lives  <= r_lives_nxt;
            r_level  <= r_level_nxt;
            r_score  <= r_score_nxt;
            r_high   <= r_high_nxt;
            r_resp   <= r_resp_nxt;
            r_hits   <= r_hits_nxt;
        end
    end

    assign game_state  = r_state;
    assign ball_active = r_active;
    assign lives       = r_lives;
    assign level       = r_level;
    assign score       = r_score;
    assign high_score  = r_high;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed scenarios then random play,
// checked against a behavioural model of the game rules.
module tb_game_flow_ctrl;

    localparam int NB   = 4;
    localparam int LV   = 3;
    localparam int RC   = 8;
    localparam int LH   = 2;
    localparam int SW   = 18;
    localparam int SMAX = (1 << SW) - 1;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          key_start;
    logic          key_pause;
    logic [NB-1:0] lost;
    logic          hit;
    logic [3:0]    game_state;
    logic [NB-1:0] ball_active;
    logic [3:0]    lives;
    logic [2:0]    level;
    logic [SW-1:0] score;
    logic [SW-1:0] high_score;

    game_flow_ctrl #(
        .NUM_BALLS      (NB),
        .LIVES          (LV),
        .RESPAWN_CYCLES (RC),
        .LEVEL_HITS     (LH),
        .SCORE_W        (SW)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst_n),
        .keyStart   (key_start),
        .keyPause   (key_pause),
        .ball_lost  (lost),
        .hit_pulse  (hit),
        .game_state (game_state),
        .ball_active(ball_active),
        .lives      (lives),
        .level      (level),
        .score      (score),
        .high_score (high_score)
    );

    typedef struct {
        int st;
        int act;
        int lives;
        int level;
        int score;
        int high;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: states 0 play, 1 over, 2 idle, 3 respawn, 4 pause
    int m_st, m_act, m_lives, m_level, m_score, m_high, m_hits, m_rem;
    int ks_h[3];
    int kp_h[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endfunction

    function automatic void model_reset();
        m_st = 2; m_act = 0; m_lives = LV; m_level = 0;
        m_score = 0; m_high = 0; m_hits = 0; m_rem = 0;
        for (int i = 0; i < 3; i++) begin
            ks_h[i] = 1;
            kp_h[i] = 1;
        end
    endfunction

    // A key value sampled three edges back, followed by a low sample, is a press now
    function automatic void model_edge();
        bit sp, pp;
        sp = (ks_h[0] == 1) && (ks_h[1] == 0);
        pp = (kp_h[0] == 1) && (kp_h[1] == 0);
        case (m_st)
            1, 2: if (sp) begin
                m_st = 0; m_act = 1; m_lives = LV; m_level = 0; m_score = 0; m_hits = 0;
            end
            0: begin
                if (PAUSE_EN && pp) begin
                    m_st = 4;
                end else begin
                    m_act = m_act & ~int'(lost);
                    if (hit) begin
                        if (m_score < SMAX) m_score++;
                        m_hits++;
                        if (m_hits == LH) begin
                            m_hits = 0;
                            if (m_level < NB - 1) begin
                                m_level++;
                                if (m_act != 0) m_act = m_act | (1 << m_level);
                            end
                        end
                    end
                    if (m_act == 0) begin
                        m_lives--;
                        if (m_lives == 0) begin
                            m_st = 1;
                            if (m_score > m_high) m_high = m_score;
                        end else begin
                            m_st = 3;
                            m_rem = RC;
                        end
                    end
                end
            end
            3: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_st = 0;
                    m_act = (1 << (m_level + 1)) - 1;
                end
            end
            4: if (pp) m_st = 0;
            default: m_st = 2;
        endcase
        ks_h[0] = ks_h[1]; ks_h[1] = ks_h[2]; ks_h[2] = int'(key_start);
        kp_h[0] = kp_h[1]; kp_h[1] = kp_h[2]; kp_h[2] = int'(key_pause);
    endfunction

    task automatic tick();
        exp_t e;
        if (!rst_n) model_reset();
        else model_edge();
        e.st = m_st; e.act = m_act; e.lives = m_lives;
        e.level = m_level; e.score = m_score; e.high = m_high;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_start();
        key_start = 1'b0;
        ticks(4);
        key_start = 1'b1;
        ticks(3);
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("game_state",  int'(game_state),  e.st);
                chk("ball_active", int'(ball_active), e.act);
                chk("lives",       int'(lives),       e.lives);
                chk("level",       int'(level),       e.level);
                chk("score",       int'(score),       e.score);
                chk("high_score",  int'(high_score),  e.high);
            end
        end
    end

    initial begin
        rst_n = 1'b0; key_start = 1'b1; key_pause = 1'b1; lost = '0; hit = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        key_start = 1'b0;
        ticks(5);
        key_start = 1'b1;
        ticks(3);

        repeat (4) begin
            hit = 1'b1; tick();
            hit = 1'b0; tick();
        end

        lost = 4'b0111; tick();
        lost = 4'b0001; ticks(12);
        lost = '0; ticks(2);

        repeat (2) begin
            lost = '1; tick();
            lost = '0; ticks(10);
        end

        press_start();
        repeat (2) begin
            hit = 1'b1; tick();
            hit = 1'b0; tick();
        end
        repeat (3) begin
            lost = '1; tick();
            lost = '0; ticks(10);
        end

        press_start();
        hit = 1'b1; tick();
        hit = 1'b0; tick();
        hit = 1'b1; lost = 4'b0001; tick();
        hit = 1'b0; lost = '0; ticks(11);

        key_pause = 1'b0; ticks(4);
        key_pause = 1'b1; ticks(2);
        hit = 1'b1; lost = 4'b0001; ticks(2);
        hit = 1'b0; lost = '0; ticks(2);
        key_pause = 1'b0; key_start = 1'b0; ticks(4);
        key_pause = 1'b1; key_start = 1'b1; ticks(3);

        press_start();
        lost = '1; tick();
        lost = '0; ticks(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(game_state),  2);
        chk("async_rst_act",   int'(ball_active), 0);
        chk("async_rst_lives", int'(lives),       LV);
        chk("async_rst_high",  int'(high_score),  0);
        chk("async_rst_score", int'(score),       0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        repeat (3000) begin
            if ($urandom_range(0, 24) == 0) key_start = ~key_start;
            if ($urandom_range(0, 24) == 0) key_pause = ~key_pause;
            hit = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 11) == 0) lost = NB'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) lost = '0;
            rst_n = ($urandom_range(0, 1499) != 0);
            tick();
        end
        rst_n = 1'b1;
        lost = '0;
        hit = 1'b0;
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
